// File: rtl/pipelined_rounding_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_rounding_unit_if
// Description : Valid/ready bus bundle for the pipelined rounding unit.
//               The input side carries the unrounded significand, exponent,
//               sign, rounding mode and external sticky. The output side
//               carries the rounded significand, exponent and flags.
//               slave  - the rounding unit's view
//               master - the producer/consumer view
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_rounding_unit_if #(
    parameter int EXP_WIDTH  = 10,
    parameter int FRAC_WIDTH = 23,
    parameter int EXTRA_BITS = 24
);
    localparam int c_F = FRAC_WIDTH + EXTRA_BITS + 2;

    logic                        in_valid;
    logic                        in_ready;
    logic                        in_sign;
    logic [2:0]                  in_mode;
    logic signed [EXP_WIDTH-1:0] in_exponent;
    logic [c_F-1:0]              in_fraction;
    logic                        in_sticky;

    logic                        out_valid;
    logic                        out_ready;
    logic                        out_sign;
    logic [EXP_WIDTH-1:0]        out_exponent;
    logic [FRAC_WIDTH:0]         out_fraction;
    logic                        out_inexact;
    logic                        out_overflow;
    logic                        out_underflow;

    modport slave (
        input  in_valid, in_sign, in_mode, in_exponent, in_fraction, in_sticky,
        input  out_ready,
        output in_ready,
        output out_valid, out_sign, out_exponent, out_fraction,
        output out_inexact, out_overflow, out_underflow
    );

    modport master (
        output in_valid, in_sign, in_mode, in_exponent, in_fraction, in_sticky,
        output out_ready,
        input  in_ready,
        input  out_valid, out_sign, out_exponent, out_fraction,
        input  out_inexact, out_overflow, out_underflow
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_rounding_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_rounding_unit
// Description : Three-stage IEEE-754 rounder (RNE/RTZ/RDN/RUP/RMM) with
//               carry renormalisation, overflow saturation and
//               inexact/overflow/underflow flags. Global stall: every stage
//               advances only when the output register is empty or drained.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous active-high reset
//               bus   - pipelined_rounding_unit_if.slave (input beat,
//                       output beat, valid/ready on both sides)
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_rounding_unit #(
    parameter int EXP_WIDTH  = 10,
    parameter int FRAC_WIDTH = 23,
    parameter int EXTRA_BITS = 24,
    parameter int EXP_MAX    = 255
) (
    input  wire logic clk,
    input  wire logic reset,
    pipelined_rounding_unit_if.slave bus
);
    localparam int c_F  = FRAC_WIDTH + EXTRA_BITS + 2;
    localparam int c_KW = FRAC_WIDTH + 1;   // kept significand incl. hidden bit
    localparam int c_SW = FRAC_WIDTH + 2;   // rounded sum incl. carry-out
    localparam int c_XW = EXP_WIDTH + 2;    // internal exponent with headroom

    localparam logic [2:0] c_MODE_RNE = 3'b000;
    localparam logic [2:0] c_MODE_RTZ = 3'b001;
    localparam logic [2:0] c_MODE_RDN = 3'b010;
    localparam logic [2:0] c_MODE_RUP = 3'b011;
    localparam logic [2:0] c_MODE_RMM = 3'b100;

    localparam logic signed [c_XW-1:0] c_EXP_LIMIT = c_XW'(EXP_MAX);
    localparam logic signed [c_XW-1:0] c_EXP_ZERO  = '0;
    localparam logic [EXP_WIDTH-1:0]   c_EXP_INF   = EXP_WIDTH'(EXP_MAX);
    localparam logic [EXP_WIDTH-1:0]   c_EXP_MAXF  = EXP_WIDTH'(EXP_MAX - 1);
    localparam logic [c_KW-1:0]        c_FRAC_ONE  = {1'b1, {FRAC_WIDTH{1'b0}}};

    // Global stall: the whole pipe moves only when the output slot is free.
    logic w_advance;
    assign w_advance    = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_advance;

    // ------------------------------------------------------------------
    // Stage 1: align on the leading integer bit, collect guard/sticky
    // ------------------------------------------------------------------
    logic                   w_s1_top;
    logic [c_KW-1:0]        w_s1_kept;
    logic                   w_s1_guard;
    logic                   w_s1_sticky;
    logic signed [c_XW-1:0] w_s1_exp;
    logic [2:0]             w_s1_mode;
    logic                   w_s1_zero;

    always_comb begin
        w_s1_top = bus.in_fraction[c_F-1];
        if (w_s1_top) begin
            w_s1_kept   = bus.in_fraction[c_F-1:EXTRA_BITS+1];
            w_s1_guard  = bus.in_fraction[EXTRA_BITS];
            w_s1_sticky = |bus.in_fraction[EXTRA_BITS-1:0];
        end else begin
            w_s1_kept   = bus.in_fraction[c_F-2:EXTRA_BITS];
            w_s1_guard  = bus.in_fraction[EXTRA_BITS-1];
            w_s1_sticky = |bus.in_fraction[EXTRA_BITS-2:0];
        end
        w_s1_sticky = w_s1_sticky | bus.in_sticky;
        w_s1_exp    = {{2{bus.in_exponent[EXP_WIDTH-1]}}, bus.in_exponent}
                    + {{(c_XW-1){1'b0}}, w_s1_top};
        // Reserved encodings collapse onto RNE here so later stages see 5 modes.
        w_s1_mode   = (bus.in_mode > c_MODE_RMM) ? c_MODE_RNE : bus.in_mode;
        w_s1_zero   = (bus.in_fraction == '0) && !bus.in_sticky;
    end

    logic                   r_s1_valid, r_s1_sign, r_s1_guard, r_s1_sticky, r_s1_zero;
    logic [2:0]             r_s1_mode;
    logic [c_KW-1:0]        r_s1_kept;
    logic signed [c_XW-1:0] r_s1_exp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_guard  <= 1'b0;
            r_s1_sticky <= 1'b0;
            r_s1_zero   <= 1'b0;
            r_s1_mode   <= '0;
            r_s1_kept   <= '0;
            r_s1_exp    <= '0;
        end else if (w_advance) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_sign   <= bus.in_sign;
                r_s1_guard  <= w_s1_guard;
                r_s1_sticky <= w_s1_sticky;
                r_s1_zero   <= w_s1_zero;
                r_s1_mode   <= w_s1_mode;
                r_s1_kept   <= w_s1_kept;
                r_s1_exp    <= w_s1_exp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: mode-dependent increment
    // ------------------------------------------------------------------
    logic            w_s2_inc;
    logic [c_SW-1:0] w_s2_sum;

    always_comb begin
        w_s2_inc = 1'b0;
        case (r_s1_mode)
            c_MODE_RNE: w_s2_inc = r_s1_guard & (r_s1_sticky | r_s1_kept[0]);
            c_MODE_RTZ: w_s2_inc = 1'b0;
            c_MODE_RDN: w_s2_inc =  r_s1_sign & (r_s1_guard | r_s1_sticky);
            c_MODE_RUP: w_s2_inc = !r_s1_sign & (r_s1_guard | r_s1_sticky);
            c_MODE_RMM: w_s2_inc = r_s1_guard;
            default:    w_s2_inc = 1'b0;
        endcase
        w_s2_sum = {1'b0, r_s1_kept} + {{c_KW{1'b0}}, w_s2_inc};
    end

    logic                   r_s2_valid, r_s2_sign, r_s2_inexact, r_s2_zero;
    logic [2:0]             r_s2_mode;
    logic [c_SW-1:0]        r_s2_sum;
    logic signed [c_XW-1:0] r_s2_exp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid   <= 1'b0;
            r_s2_sign    <= 1'b0;
            r_s2_inexact <= 1'b0;
            r_s2_zero    <= 1'b0;
            r_s2_mode    <= '0;
            r_s2_sum     <= '0;
            r_s2_exp     <= '0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign    <= r_s1_sign;
                r_s2_inexact <= r_s1_guard | r_s1_sticky;
                r_s2_zero    <= r_s1_zero;
                r_s2_mode    <= r_s1_mode;
                r_s2_sum     <= w_s2_sum;
                r_s2_exp     <= r_s1_exp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: renormalise on carry, saturate, raise flags
    // ------------------------------------------------------------------
    logic                   w_s3_carry, w_s3_ovf, w_s3_unf, w_s3_away;
    logic [c_KW-1:0]        w_s3_frac;
    logic signed [c_XW-1:0] w_s3_exp;
    logic [EXP_WIDTH-1:0]   w_o_exp;
    logic [c_KW-1:0]        w_o_frac;
    logic                   w_o_inexact;

    always_comb begin
        w_s3_carry = r_s2_sum[c_SW-1];
        // On carry-out the sum is exactly 10.000..., so the upper slice is 1.000...
        w_s3_frac  = w_s3_carry ? r_s2_sum[c_SW-1:1] : r_s2_sum[c_KW-1:0];
        w_s3_exp   = r_s2_exp + $signed({{(c_XW-1){1'b0}}, w_s3_carry});
        w_s3_ovf   = !r_s2_zero && (w_s3_exp >= c_EXP_LIMIT);
        w_s3_unf   = !r_s2_zero && !w_s3_ovf && (w_s3_exp <= c_EXP_ZERO);
        // Modes that round an overflowing magnitude up to infinity.
        w_s3_away  = (r_s2_mode == c_MODE_RNE) || (r_s2_mode == c_MODE_RMM)
                  || ((r_s2_mode == c_MODE_RUP) && !r_s2_sign)
                  || ((r_s2_mode == c_MODE_RDN) &&  r_s2_sign);

        w_o_exp     = w_s3_exp[EXP_WIDTH-1:0];
        w_o_frac    = w_s3_frac;
        w_o_inexact = r_s2_inexact;
        if (r_s2_zero) begin
            w_o_exp     = '0;
            w_o_frac    = '0;
            w_o_inexact = 1'b0;
        end else if (w_s3_ovf) begin
            w_o_inexact = 1'b1;
            if (w_s3_away) begin
                w_o_exp  = c_EXP_INF;
                w_o_frac = c_FRAC_ONE;
            end else begin
                w_o_exp  = c_EXP_MAXF;
                w_o_frac = '1;
            end
        end
    end

    logic                 r_out_valid, r_out_sign, r_out_inexact, r_out_overflow, r_out_underflow;
    logic [EXP_WIDTH-1:0] r_out_exponent;
    logic [c_KW-1:0]      r_out_fraction;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid     <= 1'b0;
            r_out_sign      <= 1'b0;
            r_out_inexact   <= 1'b0;
            r_out_overflow  <= 1'b0;
            r_out_underflow <= 1'b0;
            r_out_exponent  <= '0;
            r_out_fraction  <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_sign      <= r_s2_sign;
                r_out_inexact   <= w_o_inexact;
                r_out_overflow  <= w_s3_ovf;
                r_out_underflow <= w_s3_unf;
                r_out_exponent  <= w_o_exp;
                r_out_fraction  <= w_o_frac;
            end
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.out_sign      = r_out_sign;
    assign bus.out_exponent  = r_out_exponent;
    assign bus.out_fraction  = r_out_fraction;
    assign bus.out_inexact   = r_out_inexact;
    assign bus.out_overflow  = r_out_overflow;
    assign bus.out_underflow = r_out_underflow;
endmodule
`default_nettype wire

// File: tb/tb_pipelined_rounding_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_rounding_unit
// Description : Self-checking bench for pipelined_rounding_unit with default
//               parameters: directed vector table, backpressure, mid-flight
//               reset with latency check, and randomized beats against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_rounding_unit;
    localparam int c_EW = 10;
    localparam int c_FW = 23;
    localparam int c_EB = 24;

    typedef struct packed {
        logic              sign;
        logic [2:0]        mode;
        logic signed [9:0] exp;
        logic [48:0]       frac;
        logic              st;
    } beat_t;

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [23:0] frac;
        logic        inx;
        logic        ovf;
        logic        unf;
    } res_t;

    typedef struct {
        beat_t b;
        res_t  r;
        string name;
    } vec_t;

    typedef struct {
        res_t  r;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipelined_rounding_unit_if #(.EXP_WIDTH(c_EW), .FRAC_WIDTH(c_FW), .EXTRA_BITS(c_EB)) bus ();

    pipelined_rounding_unit #(
        .EXP_WIDTH(c_EW), .FRAC_WIDTH(c_FW), .EXTRA_BITS(c_EB), .EXP_MAX(255)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    // Reference: round by comparing the discarded remainder with one half.
    function automatic res_t model(input beat_t b);
        res_t r;
        longint unsigned f, kept, rem, half;
        int  sh, e, m;
        bit  above, tie, nz, up;
        r = '0;
        r.sign = b.sign;
        if (b.frac == '0 && !b.st) return r;
        f    = 64'(b.frac);
        sh   = b.frac[48] ? 25 : 24;
        e    = int'(b.exp) + (b.frac[48] ? 1 : 0);
        kept = f >> sh;
        rem  = f - (kept << sh);
        half = 64'd1 << (sh - 1);
        nz    = (rem != 0) || b.st;
        above = (rem > half) || (rem == half && b.st);
        tie   = (rem == half) && !b.st;
        m     = (b.mode > 3'd4) ? 0 : int'(b.mode);
        case (m)
            0:       up = above || (tie && kept[0]);
            1:       up = 1'b0;
            2:       up = b.sign && nz;
            3:       up = !b.sign && nz;
            default: up = above || tie;
        endcase
        kept = kept + 64'(up);
        if (kept == (64'd1 << 24)) begin
            kept = 64'd1 << 23;
            e    = e + 1;
        end
        r.inx = nz;
        if (e >= 255) begin
            r.ovf = 1'b1;
            r.inx = 1'b1;
            if (m == 0 || m == 4 || (m == 3 && !b.sign) || (m == 2 && b.sign)) begin
                e = 255; kept = 64'd1 << 23;
            end else begin
                e = 254; kept = 64'hFF_FFFF;
            end
        end else if (e <= 0) begin
            r.unf = 1'b1;
        end
        r.exp  = 10'(e);
        r.frac = 24'(kept);
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t       b;
        logic [63:0] w;
        int          kind, e;
        w      = {$urandom, $urandom};
        kind   = int'($urandom_range(0, 11));
        e      = int'($urandom_range(0, 270)) - 5;
        b.sign = 1'($urandom_range(0, 1));
        b.mode = 3'($urandom_range(0, 7));
        b.exp  = 10'(e);
        b.frac = w[48:0];
        b.st   = ($urandom_range(0, 3) == 0);
        if (kind < 5) b.frac[48] = 1'b1;
        else          b.frac[48:47] = 2'b01;
        case (kind)
            0:  b.frac[23:0] = 24'h00_0000;
            1:  b.frac[22:0] = 23'h0;
            2:  b.frac[47:24] = 24'hFF_FFFF;
            6:  b.frac[22:0] = 23'h0;
            7:  b.frac[46:24] = 23'h7F_FFFF;
            8:  begin b.frac = '0; b.st = 1'b0; end
            default: ;
        endcase
        return b;
    endfunction

    function automatic res_t dut_res();
        res_t a;
        a.sign = bus.out_sign;
        a.exp  = bus.out_exponent;
        a.frac = bus.out_fraction;
        a.inx  = bus.out_inexact;
        a.ovf  = bus.out_overflow;
        a.unf  = bus.out_underflow;
        return a;
    endfunction

    task automatic check_bit(input string nm, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, req);
        end
    endtask

    // Caller is positioned just after a rising edge; returns likewise.
    task automatic send(input beat_t b, input res_t r, input string nm);
        int waitc;
        bit acc;
        waitc = 0;
        acc   = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_sign     = b.sign;
        bus.in_mode     = b.mode;
        bus.in_exponent = b.exp;
        bus.in_fraction = b.frac;
        bus.in_sticky   = b.st;
        while (!acc && waitc < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) exp_q.push_back('{r: r, name: nm});
            @(posedge clk);
            #1;
            waitc++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout %s: in_ready never high, expected accept", nm);
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_%s: %0d beats outstanding, expected 0", nm, exp_q.size());
        end
    endtask

    // Output monitor: compares every delivered beat, checks stall behaviour.
    bit   stalled_prev = 1'b0;
    logic [38:0] snap;
    exp_t ex;
    res_t act;

    always @(negedge clk) begin
        if (reset) begin
            stalled_prev = 1'b0;
        end else begin
            act = dut_res();
            if (stalled_prev) begin
                total++;
                if ({bus.out_valid, act} !== snap) begin
                    bad++;
                    $display("FAIL stall_hold: got %h expected %h", {bus.out_valid, act}, snap);
                end
            end
            if (bus.out_valid && !bus.out_ready)
                check_bit("stall_in_ready", bus.in_ready, 1'b0);
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got %h expected none", act);
                end else begin
                    ex = exp_q.pop_front();
                    if (act !== ex.r) begin
                        bad++;
                        $display("FAIL %s: got %h expected %h", ex.name, act, ex.r);
                    end
                end
            end
            stalled_prev = bus.out_valid && !bus.out_ready;
            snap         = {bus.out_valid, act};
        end
    end

    vec_t vecs[$];
    bit   rnd_on;

    initial begin
        beat_t b;
        bus.in_valid    = 1'b0;
        bus.in_sign     = 1'b0;
        bus.in_mode     = '0;
        bus.in_exponent = '0;
        bus.in_fraction = '0;
        bus.in_sticky   = 1'b0;
        bus.out_ready   = 1'b1;

        //                 sign mode  exp     fraction                           st    sign exp     frac         inx  ovf  unf
        vecs.push_back('{'{1'b0, 3'd0, 10'sd127, {1'b0, 24'h800001, 24'h800000}, 1'b0}, '{1'b0, 10'd127, 24'h800002, 1'b1, 1'b0, 1'b0}, "rne_tie_odd"});
        vecs.push_back('{'{1'b0, 3'd0, 10'sd127, {1'b0, 24'h800000, 24'h800000}, 1'b0}, '{1'b0, 10'd127, 24'h800000, 1'b1, 1'b0, 1'b0}, "rne_tie_even"});
        vecs.push_back('{'{1'b0, 3'd3, 10'sd127, {1'b0, 24'hFFFFFF, 24'h000001}, 1'b0}, '{1'b0, 10'd128, 24'h800000, 1'b1, 1'b0, 1'b0}, "rup_carry"});
        vecs.push_back('{'{1'b0, 3'd0, 10'sd254, {1'b1, 48'h0000_0000_0001}, 1'b0},    '{1'b0, 10'd255, 24'h800000, 1'b1, 1'b1, 1'b0}, "ovf_rne"});
        vecs.push_back('{'{1'b0, 3'd1, 10'sd254, {1'b1, 48'h0000_0000_0001}, 1'b0},    '{1'b0, 10'd254, 24'hFFFFFF, 1'b1, 1'b1, 1'b0}, "ovf_rtz"});
        vecs.push_back('{'{1'b1, 3'd2, 10'sd254, {1'b1, 48'h0000_0000_0001}, 1'b0},    '{1'b1, 10'd255, 24'h800000, 1'b1, 1'b1, 1'b0}, "ovf_rdn_neg"});
        vecs.push_back('{'{1'b1, 3'd3, 10'sd254, {1'b1, 48'h0000_0000_0001}, 1'b0},    '{1'b1, 10'd254, 24'hFFFFFF, 1'b1, 1'b1, 1'b0}, "ovf_rup_neg"});
        vecs.push_back('{'{1'b1, 3'd2, 10'sd127, {1'b0, 24'hC00000, 24'h000000}, 1'b1}, '{1'b1, 10'd127, 24'hC00001, 1'b1, 1'b0, 1'b0}, "rdn_neg_sticky"});
        vecs.push_back('{'{1'b1, 3'd3, 10'sd127, {1'b0, 24'hC00000, 24'h000000}, 1'b1}, '{1'b1, 10'd127, 24'hC00000, 1'b1, 1'b0, 1'b0}, "rup_neg_sticky"});
        vecs.push_back('{'{1'b1, 3'd0, 10'sd50,  49'h0, 1'b0},                          '{1'b1, 10'd0,   24'h000000, 1'b0, 1'b0, 1'b0}, "zero_input"});
        vecs.push_back('{'{1'b0, 3'd4, 10'sd10,  {1'b0, 24'h800000, 24'h800000}, 1'b0}, '{1'b0, 10'd10,  24'h800001, 1'b1, 1'b0, 1'b0}, "rmm_tie"});
        vecs.push_back('{'{1'b0, 3'd0, 10'sd0,   {1'b0, 24'hA00000, 24'h000000}, 1'b0}, '{1'b0, 10'd0,   24'hA00000, 1'b0, 1'b0, 1'b1}, "underflow"});
        vecs.push_back('{'{1'b0, 3'd7, 10'sd20,  {1'b0, 24'h800003, 24'h800000}, 1'b0}, '{1'b0, 10'd20,  24'h800004, 1'b1, 1'b0, 1'b0}, "mode7_as_rne"});
        vecs.push_back('{'{1'b0, 3'd0, 10'sd5,   {1'b1, 48'h0}, 1'b0},                  '{1'b0, 10'd6,   24'h800000, 1'b0, 1'b0, 1'b0}, "top_bit_exact"});
        vecs.push_back('{'{1'b0, 3'd1, 10'sd253, {1'b1, 48'h0000_0000_0001}, 1'b0},    '{1'b0, 10'd254, 24'h800000, 1'b1, 1'b0, 1'b0}, "below_ovf"});

        // Reset state
        #1;
        check_bit("reset_out_valid", bus.out_valid, 1'b0);
        total++;
        if (dut_res() !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0", dut_res());
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_bit("in_ready_after_reset", bus.in_ready, 1'b1);

        // Directed vector table, back to back
        @(posedge clk);
        #1;
        foreach (vecs[i]) send(vecs[i].b, vecs[i].r, vecs[i].name);
        drain("table");

        // Backpressure: six beats, consumer stalls for four cycles
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    b = rand_beat();
                    send(b, model(b), $sformatf("bp_beat%0d", k));
                end
            end
            begin
                for (int c = 1; c <= 12; c++) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = !(c >= 4 && c <= 7);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain("backpressure");

        // Reset with beats in flight
        for (int k = 0; k < 3; k++) begin
            b = rand_beat();
            send(b, model(b), $sformatf("pre_reset%0d", k));
        end
        reset = 1'b1;
        #1;
        check_bit("midreset_out_valid", bus.out_valid, 1'b0);
        total++;
        if (dut_res() !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got %h expected 0", dut_res());
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_bit("in_ready_after_midreset", bus.in_ready, 1'b1);
        b = rand_beat();
        fork
            send(b, model(b), "post_reset_beat");
            begin
                @(negedge clk);
                @(negedge clk);
                check_bit("latency_edge1", bus.out_valid, 1'b0);
                @(negedge clk);
                check_bit("latency_edge2", bus.out_valid, 1'b0);
                @(negedge clk);
                check_bit("latency_edge3", bus.out_valid, 1'b1);
            end
        join
        drain("post_reset");

        // Randomized traffic with random consumer backpressure
        rnd_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    b = rand_beat();
                    send(b, model(b), $sformatf("rand%0d", k));
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
